// File: rtl/mem_io_pkg.sv
// Shared constants, types and address decode for the CPU memory/I-O responder.
package mem_io_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEC_W  = 18;

  localparam logic [1:0] IO_SEL  = 2'b11;
  localparam logic [2:0] IO_UART = 3'd0;
  localparam logic [2:0] IO_CLK  = 3'd4;

  typedef logic [DATA_W-1:0] byte_t;

  typedef struct packed {
    logic       is_io;
    logic       io_uart;
    logic       io_clk;
    logic [1:0] byte_sel;
  } io_dec_t;

  // Registers outside the 8-byte window at 0x30000 decode to nothing.
  function automatic io_dec_t decode(input logic [DEC_W-1:0] a);
    io_dec_t d;
    logic    hit;
    d.is_io    = (a[17:16] == IO_SEL);
    hit        = d.is_io && (a[15:3] == 13'd0);
    d.io_uart  = hit && (a[2:0] == IO_UART);
    d.io_clk   = hit && (a[2:0] >= IO_CLK);
    d.byte_sel = a[1:0];
    return d;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-side byte-wide memory bus between the core (master) and the responder (slave).
interface mem_io_responder_if;
  import mem_io_pkg::*;

  logic [ADDR_W-1:0] mem_a;
  byte_t             mem_dout;
  logic              mem_wr;
  byte_t             mem_din;
  logic              io_buffer_full;
  logic              rdy_out;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full, rdy_out
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full, rdy_out
  );
endinterface

// File: rtl/byte_fifo.sv
// Circular byte FIFO with power-of-two depth; storage is reset so the head reads 0 when empty.
module byte_fifo
  import mem_io_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  byte_t                  data_i,
  input  logic                   pop_i,
  output byte_t                  data_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  byte_t          buf_q [DEPTH];
  logic [PW-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]  count_d, count_q;
  logic           do_push_c, do_pop_c;

  assign full_o        = (count_q == CW'(DEPTH));
  assign almost_full_o = (count_q >= CW'(DEPTH - 1));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign data_o        = buf_q[rd_ptr_q];

  assign do_push_c = push_i && !full_o;
  assign do_pop_c  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push_c);
    rd_ptr_d = rd_ptr_q + PW'(do_pop_c);
    count_d  = count_q;
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_c) buf_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: byte RAM plus the I/O window (UART TX/RX,
// cycle counter with snapshot, program-stop latch). Read data lands one cycle later.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned RAM_AW   = 17,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  input  byte_t             rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output byte_t             tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              halted,
  output logic              tx_overflow
);

  localparam int unsigned RAM_BYTES = 2 ** RAM_AW;
  localparam int unsigned CW        = $clog2(TX_DEPTH) + 1;

  byte_t             ram_q [RAM_BYTES];
  logic [RAM_AW-1:0] ram_addr_c;
  byte_t             ram_rd_c;

  io_dec_t           dec_c;
  logic              active_c, rd_c, ram_we_c, snap_ld_c, halt_c;
  logic              push_req_c, fifo_push_c, fifo_pop_c;
  logic              fifo_full_c, fifo_afull_c, fifo_empty_c;
  byte_t             push_data_c;

  byte_t             mem_din_d, mem_din_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, snap_d, snap_q;
  logic              halted_d, halted_q, rdy_d, rdy_q, ovf_d, ovf_q;

  logic [CW-1:0]     unused_count_c;
  logic              unused_addr_c;

  assign dec_c          = decode(bus.mem_a[DEC_W-1:0]);
  assign unused_addr_c  = ^bus.mem_a[ADDR_W-1:DEC_W];
  assign ram_addr_c     = bus.mem_a[RAM_AW-1:0];
  assign ram_rd_c       = ram_q[ram_addr_c];

  // Every side effect is frozen once the program has stopped.
  assign active_c    = !halted_q;
  assign rd_c        = !bus.mem_wr;
  assign ram_we_c    = active_c && bus.mem_wr && !dec_c.is_io;
  assign rx_pop      = active_c && rd_c && dec_c.io_uart && rx_valid;
  assign snap_ld_c   = active_c && rd_c && dec_c.io_clk && (dec_c.byte_sel == 2'd0);
  assign halt_c      = active_c && bus.mem_wr && dec_c.io_clk && (dec_c.byte_sel == 2'd0);

  // The halt marker byte 0x00 bypasses the zero-ignore rule on UART writes.
  assign push_req_c  = halt_c || (active_c && bus.mem_wr && dec_c.io_uart && (bus.mem_dout != '0));
  assign push_data_c = halt_c ? '0 : bus.mem_dout;
  assign fifo_push_c = push_req_c && !fifo_full_c;
  assign fifo_pop_c  = tx_valid && tx_ready;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i         (clk_in),
    .rst_ni        (rst_in),
    .push_i        (fifo_push_c),
    .data_i        (push_data_c),
    .pop_i         (fifo_pop_c),
    .data_o        (tx_data),
    .full_o        (fifo_full_c),
    .almost_full_o (fifo_afull_c),
    .empty_o       (fifo_empty_c),
    .count_o       (unused_count_c)
  );

  always_ff @(posedge clk_in) begin
    if (ram_we_c) ram_q[ram_addr_c] <= bus.mem_dout;
  end

  // Byte 0 of the counter comes from the live value in the same cycle the snapshot loads.
  always_comb begin
    mem_din_d = mem_din_q;
    if (rd_c) begin
      if (!dec_c.is_io) begin
        mem_din_d = ram_rd_c;
      end else if (dec_c.io_uart) begin
        mem_din_d = rx_pop ? rx_data : '0;
      end else if (dec_c.io_clk) begin
        case (dec_c.byte_sel)
          2'd0:    mem_din_d = cnt_q[7:0];
          2'd1:    mem_din_d = snap_q[15:8];
          2'd2:    mem_din_d = snap_q[23:16];
          default: mem_din_d = snap_q[31:24];
        endcase
      end else begin
        mem_din_d = '0;
      end
    end
  end

  always_comb begin
    cnt_d    = active_c ? cnt_q + CNT_W'(1) : cnt_q;
    snap_d   = snap_ld_c ? cnt_q : snap_q;
    halted_d = halted_q || halt_c;
    rdy_d    = rdy_q && !halt_c;
    ovf_d    = ovf_q || (push_req_c && fifo_full_c);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      halted_q  <= 1'b0;
      rdy_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      halted_q  <= halted_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = fifo_afull_c;
  assign bus.rdy_out        = rdy_q;
  assign tx_valid           = !fifo_empty_c;
  assign halted             = halted_q;
  assign tx_overflow        = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, UART TX/RX, counter, FIFO full, halt.
module tb_mem_io_responder;

  logic       clk_in;
  logic       rst_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       halted;
  logic       tx_overflow;

  int checks;
  int errors;

  mem_io_responder_if bus_if ();

  mem_io_responder #(.RAM_AW(17), .TX_DEPTH(8)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bus_if),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_pop      (rx_pop),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .halted      (halted),
    .tx_overflow (tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus_if.mem_a    = a;
    bus_if.mem_wr   = wr;
    bus_if.mem_dout = d;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(32'h0000_0010, 1'b0, 8'h00);
    step(); step();
    checks++; if (bus_if.mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din: got %h expected 00", bus_if.mem_din); end
    checks++; if (bus_if.rdy_out !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", bus_if.rdy_out); end
    checks++; if (bus_if.io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus_if.io_buffer_full); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", tx_overflow); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop: got %b expected 0", rx_pop); end
    rst_in = 1'b1;
  endtask

  task automatic test_ram();
    drive(32'h0000_0123, 1'b1, 8'h5A); step();
    drive(32'h0000_0123, 1'b0, 8'h00); step();
    checks++; if (bus_if.mem_din !== 8'h5A) begin errors++; $display("FAIL ram_raw: got %h expected 5a", bus_if.mem_din); end
    drive(32'h0001_FFFF, 1'b1, 8'hC3); step();
    drive(32'h0000_0123, 1'b0, 8'h00); step();
    checks++; if (bus_if.mem_din !== 8'h5A) begin errors++; $display("FAIL ram_keep: got %h expected 5a", bus_if.mem_din); end
    drive(32'h0001_FFFF, 1'b0, 8'h00); step();
    checks++; if (bus_if.mem_din !== 8'hC3) begin errors++; $display("FAIL ram_top: got %h expected c3", bus_if.mem_din); end
    drive(32'h0000_0300, 1'b1, 8'h11); step();
    checks++; if (bus_if.mem_din !== 8'hC3) begin errors++; $display("FAIL ram_hold_on_wr: got %h expected c3", bus_if.mem_din); end
  endtask

  task automatic test_uart_tx();
    tx_ready = 1'b0;
    drive(32'h0003_0000, 1'b1, 8'h41); step();
    drive(32'h0003_0000, 1'b1, 8'h00); step();
    drive(32'h0003_0000, 1'b1, 8'h42); step();
    drive(32'h0000_0123, 1'b0, 8'h00); step();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_filled: got %b expected 1", tx_valid); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_head0: got %h expected 41", tx_data); end
    tx_ready = 1'b1; step();
    checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL tx_head1: got %h expected 42", tx_data); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_one: got %b expected 1", tx_valid); end
    step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h37;
    drive(32'h0003_0000, 1'b0, 8'h00); #1;
    checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_hi: got %b expected 1", rx_pop); end
    step();
    checks++; if (bus_if.mem_din !== 8'h37) begin errors++; $display("FAIL rx_data: got %h expected 37", bus_if.mem_din); end
    rx_valid = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00); #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_lo: got %b expected 0", rx_pop); end
    step();
    checks++; if (bus_if.mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty: got %h expected 00", bus_if.mem_din); end
    drive(32'h0000_0123, 1'b0, 8'h00); step();
    drive(32'h0003_0008, 1'b0, 8'h00); step();
    checks++; if (bus_if.mem_din !== 8'h00) begin errors++; $display("FAIL io_hole_rd: got %h expected 00", bus_if.mem_din); end
    drive(32'h0003_0001, 1'b1, 8'h66); step();
    drive(32'h0000_0123, 1'b0, 8'h00); step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL io_hole_wr: got %b expected 0", tx_valid); end
  endtask

  task automatic test_counter();
    logic [31:0] v1, v2;
    rst_in = 1'b0; drive(32'h0000_0123, 1'b0, 8'h00); step();
    rst_in = 1'b1;
    repeat (99) step();
    // Byte 0 at the 100th edge after reset sees the pre-edge count of 99.
    for (int k = 0; k < 4; k++) begin
      drive(32'h0003_0004 + 32'(k), 1'b0, 8'h00); step();
      v1[8*k +: 8] = bus_if.mem_din;
    end
    checks++; if (v1 < 32'd99 || v1 > 32'd101) begin errors++; $display("FAIL cnt_100: got %0d expected 99..101", v1); end
    drive(32'h0000_0123, 1'b0, 8'h00);
    repeat (300) step();
    drive(32'h0003_0005, 1'b0, 8'h00); step();
    checks++; if (bus_if.mem_din !== 8'h00) begin errors++; $display("FAIL snap_no_reload: got %h expected 00", bus_if.mem_din); end
    for (int k = 0; k < 4; k++) begin
      drive(32'h0003_0004 + 32'(k), 1'b0, 8'h00); step();
      v2[8*k +: 8] = bus_if.mem_din;
    end
    checks++; if (v2 !== 32'd404) begin errors++; $display("FAIL cnt_404: got %0d expected 404", v2); end
    drive(32'h0000_0123, 1'b0, 8'h00);
  endtask

  task automatic test_full();
    tx_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(32'h0003_0000, 1'b1, 8'h10 + 8'(k)); step();
      checks++; if (bus_if.io_buffer_full !== (k >= 7)) begin errors++; $display("FAIL almost_full_%0d: got %b expected %b", k, bus_if.io_buffer_full, (k >= 7)); end
    end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", tx_overflow); end
    drive(32'h0003_0000, 1'b1, 8'h19); step();
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", tx_overflow); end
    drive(32'h0000_0123, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (tx_data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL drain_%0d: got %h expected %h", k, tx_data, 8'h10 + 8'(k)); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_halt();
    rst_in = 1'b0; drive(32'h0000_0123, 1'b0, 8'h00); step();
    rst_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(32'h0003_0000, 1'b1, 8'h21 + 8'(k)); step();
    end
    tx_ready = 1'b1; drive(32'h0000_0123, 1'b0, 8'h00);
    repeat (8) step();
    tx_ready = 1'b0;
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL halt_pre_ovf: got %b expected 1", tx_overflow); end
    // Counter is 17 here; the halting edge still counts, freezing it at 18.
    drive(32'h0003_0004, 1'b1, 8'hFF); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_set: got %b expected 1", halted); end
    checks++; if (bus_if.rdy_out !== 1'b0) begin errors++; $display("FAIL rdy_drop: got %b expected 0", bus_if.rdy_out); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL halt_push_valid: got %b expected 1", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL halt_push_data: got %h expected 00", tx_data); end
    drive(32'h0000_0123, 1'b1, 8'h99); step();
    drive(32'h0000_0123, 1'b0, 8'h00); step();
    checks++; if (bus_if.mem_din !== 8'h5A) begin errors++; $display("FAIL halt_ram: got %h expected 5a", bus_if.mem_din); end
    rx_valid = 1'b1; rx_data = 8'h37;
    drive(32'h0003_0000, 1'b0, 8'h00); #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL halt_rx_pop: got %b expected 0", rx_pop); end
    step();
    rx_valid = 1'b0;
    checks++; if (bus_if.mem_din !== 8'h00) begin errors++; $display("FAIL halt_rx_data: got %h expected 00", bus_if.mem_din); end
    drive(32'h0003_0004, 1'b0, 8'h00);
    repeat (5) step();
    checks++; if (bus_if.mem_din !== 8'h12) begin errors++; $display("FAIL cnt_frozen: got %h expected 12", bus_if.mem_din); end
    rst_in = 1'b0; #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_async_fifo: got %b expected 0", tx_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
    checks++; if (bus_if.rdy_out !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b expected 1", bus_if.rdy_out); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", tx_overflow); end
    checks++; if (bus_if.mem_din !== 8'h00) begin errors++; $display("FAIL rst_mem_din: got %h expected 00", bus_if.mem_din); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    step();
    rst_in = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram();
    test_uart_tx();
    test_rx();
    test_counter();
    test_full();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
